// File: rtl/key_sw_device_pkg.sv
// Shared constants for the KEY/SW input responder: register map, CTRL bit
// positions, device widths and the per-device status update rule.
package key_sw_device_pkg;

    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

    localparam int unsigned CTRL_RDY = 0;
    localparam int unsigned CTRL_OVR = 1;
    localparam int unsigned CTRL_IE  = 4;

    localparam int unsigned KEY_WIDTH = 4;
    localparam int unsigned SW_WIDTH  = 10;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } dev_status_t;

    // CTRL register image: IE at bit 4, OVR at bit 1, RDY at bit 0.
    function automatic logic [31:0] ctrl_word(input dev_status_t st);
        logic [31:0] w;
        w = '0;
        w[CTRL_IE]  = st.ie;
        w[CTRL_OVR] = st.ovr;
        w[CTRL_RDY] = st.rdy;
        return w;
    endfunction

    // Next status for one device. A new value always wins over a read-clear,
    // and an overrun set wins over a software clear in the same cycle.
    function automatic dev_status_t status_next(
        input dev_status_t cur,
        input logic        upd,
        input logic        data_rd,
        input logic        ctrl_wr,
        input logic        wr_ovr,
        input logic        wr_ie
    );
        dev_status_t nxt;
        nxt = cur;
        if (upd)
            nxt.rdy = 1'b1;
        else if (data_rd)
            nxt.rdy = 1'b0;
        if (upd && cur.rdy && !data_rd)
            nxt.ovr = 1'b1;
        else if (ctrl_wr && !wr_ovr)
            nxt.ovr = 1'b0;
        if (ctrl_wr)
            nxt.ie = wr_ie;
        return nxt;
    endfunction

endpackage

// File: rtl/key_sw_device_debounce_sync.sv
// Two-flop synchronizer plus stability counter and held data register for
// one group of raw inputs. Emits the held value and a one-cycle update strobe
// that is high on the edge where the held value is loaded.
module debounce_sync #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_BITS        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             update
);

    logic [WIDTH-1:0]    sync1;
    logic [WIDTH-1:0]    sync2;
    logic [CNT_BITS-1:0] count;
    logic                stable;

    // Change detection compares the synchronizer stages, i.e. the synchronized
    // vector against the value it will take next; this gives a total latency
    // of 2 + DEBOUNCE_CYCLES edges from first sample to held value.
    assign stable = (sync1 == sync2) && (sync2 != value);
    assign update = stable && (count == CNT_BITS'(DEBOUNCE_CYCLES - 1));

    // Two-flop synchronizer for the raw inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Stability counter and held value; counter restarts on any change or update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            value <= '0;
        end else begin
            if (!stable || update)
                count <= '0;
            else
                count <= count + 1'b1;
            if (update)
                value <= sync2;
        end
    end

endmodule

// File: rtl/key_sw_device.sv
// Memory-mapped KEY/SW input responder: debounced data registers, per-device
// ready/overrun/interrupt-enable status, combinational read decode and an
// interrupt request derived directly from the status flops.
module key_sw_device
    import key_sw_device_pkg::*;
#(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_BITS        = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] KEY,
    input  logic [SW_WIDTH-1:0]  SW,
    input  logic [DBITS-1:0]     addr,
    input  logic                 re,
    input  logic                 we,
    input  logic [DBITS-1:0]     wdata,
    output logic [DBITS-1:0]     rdata,
    output logic                 sel,
    output logic                 intr
);

    logic [KEY_WIDTH-1:0] key_raw;
    logic [KEY_WIDTH-1:0] key_value;
    logic [SW_WIDTH-1:0]  sw_value;
    logic                 key_update;
    logic                 sw_update;
    dev_status_t          key_st;
    dev_status_t          sw_st;
    logic                 hit_kdata;
    logic                 hit_sdata;
    logic                 hit_kctrl;
    logic                 hit_sctrl;
    logic                 unused_wdata;

    // Buttons are active-low on the pins; present pressed as 1.
    assign key_raw = ~KEY;

    debounce_sync #(
        .WIDTH(KEY_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS(CNT_BITS)
    ) key_db (
        .clk(clk),
        .reset(reset),
        .raw(key_raw),
        .value(key_value),
        .update(key_update)
    );

    debounce_sync #(
        .WIDTH(SW_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS(CNT_BITS)
    ) sw_db (
        .clk(clk),
        .reset(reset),
        .raw(SW),
        .value(sw_value),
        .update(sw_update)
    );

    assign hit_kdata = (addr == DBITS'(ADDR_KEY));
    assign hit_sdata = (addr == DBITS'(ADDR_SW));
    assign hit_kctrl = (addr == DBITS'(ADDR_KCTRL));
    assign hit_sctrl = (addr == DBITS'(ADDR_SCTRL));

    assign unused_wdata = ^{wdata[DBITS-1:CTRL_IE+1], wdata[CTRL_IE-1:CTRL_OVR+1], wdata[CTRL_RDY]};

    // Per-device ready/overrun/IE status; reads and writes act independently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_st <= '0;
            sw_st  <= '0;
        end else begin
            key_st <= status_next(key_st, key_update, re && hit_kdata, we && hit_kctrl,
                                  wdata[CTRL_OVR], wdata[CTRL_IE]);
            sw_st  <= status_next(sw_st, sw_update, re && hit_sdata, we && hit_sctrl,
                                  wdata[CTRL_OVR], wdata[CTRL_IE]);
        end
    end

    // Read data and select decode, combinational from addr alone.
    always_comb begin
        rdata = '0;
        sel   = 1'b1;
        if (hit_kdata)
            rdata = DBITS'(key_value);
        else if (hit_sdata)
            rdata = DBITS'(sw_value);
        else if (hit_kctrl)
            rdata = DBITS'(ctrl_word(key_st));
        else if (hit_sctrl)
            rdata = DBITS'(ctrl_word(sw_st));
        else
            sel = 1'b0;
    end

    assign intr = (key_st.rdy & key_st.ie) | (sw_st.rdy & sw_st.ie);

endmodule

// File: tb/tb_key_sw_device.sv
// Scoreboard bench for key_sw_device: the driver advances a window-based
// reference model each edge and queues the expected bus view; a monitor
// compares the DUT against the queue on the falling edge.
module tb_key_sw_device;
    import key_sw_device_pkg::*;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        intr;

    key_sw_device #(
        .DBITS(32),
        .DEBOUNCE_CYCLES(D),
        .CNT_BITS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .KEY(KEY),
        .SW(SW),
        .addr(addr),
        .re(re),
        .we(we),
        .wdata(wdata),
        .rdata(rdata),
        .sel(sel),
        .intr(intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        sl;
        logic        irq;
        int          fsel;   // 0 none, 1 rdata, 2 intr, 3 sel
        logic [31:0] fv;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: device 0 = KEY (pressed=1), device 1 = SW.
    // A value is accepted when the last D+1 samples all agree and differ
    // from the held value.
    logic [9:0] hist[2][D+1];
    logic [9:0] m_data[2];
    bit         m_rdy[2];
    bit         m_ovr[2];
    bit         m_ie[2];

    function automatic logic [31:0] data_addr(input int d);
        return (d == 0) ? ADDR_KEY : ADDR_SW;
    endfunction

    function automatic logic [31:0] ctrl_addr(input int d);
        return (d == 0) ? ADDR_KCTRL : ADDR_SCTRL;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i <= int'(D); i++) hist[d][i] = '0;
            m_data[d] = '0;
            m_rdy[d]  = 0;
            m_ovr[d]  = 0;
            m_ie[d]   = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] k, input logic [9:0] s, input logic [31:0] a,
                              input logic r, input logic w, input logic [31:0] wd);
        logic [9:0] smp[2];
        smp[0] = {6'b0, ~k};
        smp[1] = s;
        for (int d = 0; d < 2; d++) begin
            bit same, upd, rd, wr, set;
            same = 1;
            for (int i = 1; i <= int'(D); i++)
                if (hist[d][i] != hist[d][0]) same = 0;
            upd = same && (hist[d][0] != m_data[d]);
            rd  = r && (a == data_addr(d));
            wr  = w && (a == ctrl_addr(d));
            set = upd && m_rdy[d] && !rd;
            if (upd) m_data[d] = hist[d][0];
            if (upd) m_rdy[d] = 1;
            else if (rd) m_rdy[d] = 0;
            if (set) m_ovr[d] = 1;
            else if (wr && !wd[1]) m_ovr[d] = 0;
            if (wr) m_ie[d] = wd[4];
            for (int i = 0; i < int'(D); i++) hist[d][i] = hist[d][i+1];
            hist[d][D] = smp[d];
        end
    endtask

    function automatic exp_t model_out(input logic [31:0] a);
        exp_t e;
        e.rd  = 0;
        e.sl  = 1;
        e.fsel = 0;
        e.fv  = 0;
        e.nm  = "";
        if (a == ADDR_KEY)        e.rd = 32'(m_data[0]);
        else if (a == ADDR_SW)    e.rd = 32'(m_data[1]);
        else if (a == ADDR_KCTRL) e.rd = (m_ie[0] ? 32'd16 : 32'd0) + (m_ovr[0] ? 32'd2 : 32'd0) + (m_rdy[0] ? 32'd1 : 32'd0);
        else if (a == ADDR_SCTRL) e.rd = (m_ie[1] ? 32'd16 : 32'd0) + (m_ovr[1] ? 32'd2 : 32'd0) + (m_rdy[1] ? 32'd1 : 32'd0);
        else e.sl = 0;
        e.irq = (m_rdy[0] && m_ie[0]) || (m_rdy[1] && m_ie[1]);
        return e;
    endfunction

    // One bus cycle: advance the model over the edge, drive new inputs, queue expectations.
    task automatic cyc(input logic [3:0] k, input logic [9:0] s, input logic [31:0] a,
                       input logic r, input logic w, input logic [31:0] wd, input logic rst,
                       input int fsel, input logic [31:0] fv, input string nm);
        exp_t e;
        @(posedge clk);
        if (reset) model_step(KEY, SW, addr, re, we, wdata);
        else model_reset();
        #1;
        KEY = k; SW = s; addr = a; re = r; we = w; wdata = wd; reset = rst;
        if (!rst) model_reset();
        e = model_out(a);
        e.fsel = fsel;
        e.fv = fv;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic obs(input logic [31:0] a, input int fsel, input logic [31:0] fv, input string nm);
        cyc(KEY, SW, a, 1'b0, 1'b0, 32'h0, 1'b1, fsel, fv, nm);
    endtask

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s got %h need %h", nm, what, act, exp);
        end
    endtask

    // Monitor: compare the DUT bus view against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "rdata", rdata, e.rd);
                chk(e.nm, "sel", 32'(sel), 32'(e.sl));
                chk(e.nm, "intr", 32'(intr), 32'(e.irq));
                if (e.fsel == 1) chk(e.nm, "rdata_fixed", rdata, e.fv);
                if (e.fsel == 2) chk(e.nm, "intr_fixed", 32'(intr), e.fv);
                if (e.fsel == 3) chk(e.nm, "sel_fixed", 32'(sel), e.fv);
            end
        end
    end

    initial begin
        logic [31:0] atab[6];
        logic [3:0]  rk;
        logic [9:0]  rs;
        atab[0] = ADDR_KEY;  atab[1] = ADDR_SW; atab[2] = ADDR_KCTRL;
        atab[3] = ADDR_SCTRL; atab[4] = 32'hF000_0018;
        reset = 1'b0; KEY = 4'hF; SW = '0; addr = '0; re = 0; we = 0; wdata = '0;
        model_reset();

        // Power-on reset and release.
        repeat (3) cyc(4'hF, 10'h0, ADDR_KCTRL, 0, 0, 0, 1'b0, 1, 0, "por");
        cyc(4'hF, 10'h0, ADDR_SW, 0, 0, 0, 1'b1, 0, 0, "por_rel");
        repeat (3) obs(ADDR_SCTRL, 1, 0, "idle");

        // Reset mid-debounce with all switches on.
        cyc(4'hF, 10'h3FF, ADDR_SW, 0, 0, 0, 1'b1, 0, 0, "sw_on");
        obs(ADDR_SW, 1, 0, "sw_mid");
        cyc(4'hF, 10'h3FF, ADDR_KEY,   0, 0, 0, 1'b0, 1, 0, "rst_kdata");
        cyc(4'hF, 10'h3FF, ADDR_SW,    0, 0, 0, 1'b0, 1, 0, "rst_sdata");
        cyc(4'hF, 10'h3FF, ADDR_KCTRL, 0, 0, 0, 1'b0, 1, 0, "rst_kctrl");
        cyc(4'hF, 10'h3FF, ADDR_SCTRL, 0, 0, 0, 1'b0, 1, 0, "rst_sctrl");
        cyc(4'hF, 10'h3FF, ADDR_SCTRL, 0, 0, 0, 1'b0, 2, 0, "rst_intr");
        cyc(4'hF, 10'h3FF, ADDR_SW,    0, 0, 0, 1'b1, 1, 0, "rst_rel");
        for (int i = 1; i <= 5; i++) obs(ADDR_SW, 1, 0, "sw_wait");
        obs(ADDR_SW, 1, 32'h3FF, "sw_edge6");
        obs(ADDR_SCTRL, 1, 32'h1, "sctrl_rdy");

        // Glitch on KEY[2] shorter than the debounce window.
        repeat (3) cyc(4'hB, 10'h3FF, ADDR_KEY, 0, 0, 0, 1'b1, 1, 0, "glitch");
        repeat (20) cyc(4'hF, 10'h3FF, ADDR_KEY, 0, 0, 0, 1'b1, 1, 0, "glitch_hold");
        obs(ADDR_KCTRL, 1, 0, "glitch_rdy");

        // Held press of KEY[2].
        for (int i = 1; i <= 6; i++) cyc(4'hB, 10'h3FF, ADDR_KEY, 0, 0, 0, 1'b1, 1, 0, "key_wait");
        obs(ADDR_KEY, 1, 32'h4, "key_edge6");
        obs(ADDR_KCTRL, 1, 32'h1, "key_rdy");
        repeat (2) obs(ADDR_KEY, 1, 32'h4, "key_hold");

        // Read clears KEY ready.
        cyc(4'hB, 10'h3FF, ADDR_KEY, 1, 0, 0, 1'b1, 1, 32'h4, "kread");
        obs(ADDR_KCTRL, 1, 0, "kread_clr");

        // Overrun on SW, then clear OVR while enabling IE.
        repeat (8) cyc(4'hB, 10'h001, ADDR_SCTRL, 0, 0, 0, 1'b1, 0, 0, "ovr_wait");
        obs(ADDR_SW, 1, 32'h1, "ovr_data");
        obs(ADDR_SCTRL, 1, 32'h3, "ovr_set");
        cyc(4'hB, 10'h001, ADDR_SCTRL, 0, 1, 32'h10, 1'b1, 0, 0, "sctrl_wr");
        obs(ADDR_SCTRL, 1, 32'h11, "ovr_clr");

        // Update edge coincides with a SW data read.
        repeat (5) cyc(4'hB, 10'h155, ADDR_SCTRL, 0, 0, 0, 1'b1, 0, 0, "coll_wait");
        cyc(4'hB, 10'h155, ADDR_SW, 1, 0, 0, 1'b1, 1, 32'h1, "coll_rd");
        obs(ADDR_SCTRL, 1, 32'h11, "coll_st");
        obs(ADDR_SW, 1, 32'h155, "coll_data");

        // Interrupt from KEY, cleared by a data read; unmapped decode.
        cyc(4'hB, 10'h155, ADDR_SCTRL, 0, 1, 32'h0, 1'b1, 0, 0, "sie_off");
        cyc(4'hB, 10'h155, ADDR_KCTRL, 0, 1, 32'h10, 1'b1, 2, 0, "kie_on");
        repeat (8) cyc(4'hA, 10'h155, ADDR_KCTRL, 0, 0, 0, 1'b1, 0, 0, "k0_wait");
        obs(ADDR_KCTRL, 2, 1, "intr_set");
        cyc(4'hA, 10'h155, ADDR_KEY, 1, 0, 0, 1'b1, 1, 32'h5, "kread2");
        obs(ADDR_KCTRL, 2, 0, "intr_clr");
        obs(32'hF000_0018, 3, 0, "unm_sel");
        obs(32'hF000_0018, 1, 0, "unm_rd");

        // Randomized traffic against the model.
        rk = KEY; rs = SW;
        for (int n = 0; n < 3000; n++) begin
            int pick;
            if ($urandom_range(0, 15) == 0) rk = 4'($urandom);
            if ($urandom_range(0, 15) == 0) rs = 10'($urandom);
            pick = $urandom_range(0, 5);
            atab[5] = $urandom;
            cyc(rk, rs, atab[pick], ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                $urandom, ($urandom_range(0, 499) != 0), 0, 0, "rand");
        end
        obs(ADDR_KCTRL, 0, 0, "tail");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d queued need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
